// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: decode, operand forwarding, load-use stall,
// branch/jump resolution and a registered ID/EX boundary with valid/ready handshake.
module id_stage_pipe #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned RADDR_W       = 5,
  parameter int unsigned FWD_PORTS     = 2,
  parameter int unsigned LOAD_STALL_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           if_valid,
  output logic                           if_ready,
  input  logic [31:0]                    if_inst,
  input  logic [ADDR_W-1:0]              if_addr,
  output logic                           rf_r1_en,
  output logic                           rf_r2_en,
  output logic [RADDR_W-1:0]             rf_r1_addr,
  output logic [RADDR_W-1:0]             rf_r2_addr,
  input  logic [DATA_W-1:0]              rf_r1_data,
  input  logic [DATA_W-1:0]              rf_r2_data,
  input  logic [FWD_PORTS-1:0]           fwd_en,
  input  logic [FWD_PORTS*RADDR_W-1:0]   fwd_addr,
  input  logic [FWD_PORTS*DATA_W-1:0]    fwd_data,
  input  logic [FWD_PORTS-1:0]           fwd_is_load,
  output logic                           jump_en,
  output logic [ADDR_W-1:0]              jump_addr,
  output logic                           ex_valid,
  input  logic                           ex_ready,
  output logic [3:0]                     ex_alu,
  output logic [DATA_W-1:0]              ex_oprd1,
  output logic [DATA_W-1:0]              ex_oprd2,
  output logic [RADDR_W:0]               ex_wreg
);

  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAdd  = 4'd1;
  localparam logic [3:0] AluSub  = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSrl  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;
  localparam logic [3:0] AluLoad = 4'd11;

  typedef enum logic [2:0] {BrNone, BrEq, BrNe, BrLez, BrGtz, BrJmp, BrReg} br_e;
  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e state_q, state_d;

  logic [5:0]         opcode, funct;
  logic [4:0]         shamt;
  logic [15:0]        imm16;
  logic [RADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]  imm_sext, imm_zext, imm_lui, link_val;
  logic [ADDR_W-1:0]  pc4, br_tgt, j_tgt;

  assign opcode   = if_inst[31:26];
  assign rs       = RADDR_W'(if_inst[25:21]);
  assign rt       = RADDR_W'(if_inst[20:16]);
  assign rd       = RADDR_W'(if_inst[15:11]);
  assign shamt    = if_inst[10:6];
  assign funct    = if_inst[5:0];
  assign imm16    = if_inst[15:0];
  assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};
  assign imm_lui  = {imm16, {(DATA_W-16){1'b0}}};
  assign link_val = DATA_W'(if_addr + ADDR_W'(8));
  assign pc4      = if_addr + ADDR_W'(4);
  assign br_tgt   = pc4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt    = {pc4[ADDR_W-1:28], if_inst[25:0], 2'b00};

  logic [3:0]         dec_alu;
  logic               r1_en, r2_en, wr_en, link, rr, ri;
  logic [RADDR_W-1:0] r1_addr, r2_addr, wr_addr;
  logic [DATA_W-1:0]  imm;
  br_e                br;

  always_comb begin
    dec_alu = AluNop;
    r1_en   = 1'b0;
    r2_en   = 1'b0;
    r1_addr = rs;
    r2_addr = rt;
    wr_en   = 1'b0;
    wr_addr = rd;
    imm     = '0;
    br      = BrNone;
    link    = 1'b0;
    rr      = 1'b0;
    ri      = 1'b0;
    case (opcode)
      6'h00: begin
        imm = DATA_W'(shamt);
        case (funct)
          6'h00: begin dec_alu = AluSll; r2_en = 1'b1; wr_en = 1'b1; end
          6'h02: begin dec_alu = AluSrl; r2_en = 1'b1; wr_en = 1'b1; end
          6'h03: begin dec_alu = AluSra; r2_en = 1'b1; wr_en = 1'b1; end
          6'h08: begin r1_en = 1'b1; br = BrReg; end
          6'h09: begin
            r1_en = 1'b1; br = BrReg; link = 1'b1; wr_en = 1'b1;
            dec_alu = AluOr; imm = link_val;
          end
          6'h21: begin dec_alu = AluAdd;  rr = 1'b1; end
          6'h23: begin dec_alu = AluSub;  rr = 1'b1; end
          6'h24: begin dec_alu = AluAnd;  rr = 1'b1; end
          6'h25: begin dec_alu = AluOr;   rr = 1'b1; end
          6'h26: begin dec_alu = AluXor;  rr = 1'b1; end
          6'h2a: begin dec_alu = AluSlt;  rr = 1'b1; end
          6'h2b: begin dec_alu = AluSltu; rr = 1'b1; end
          default: ;
        endcase
      end
      6'h02: br = BrJmp;
      // Link value travels as imm in oprd2; oprd1 is forced to 0 at the register.
      6'h03: begin
        br = BrJmp; link = 1'b1; wr_en = 1'b1; wr_addr = RADDR_W'(31);
        dec_alu = AluOr; imm = link_val;
      end
      6'h04: begin br = BrEq;  r1_en = 1'b1; r2_en = 1'b1; imm = imm_sext; end
      6'h05: begin br = BrNe;  r1_en = 1'b1; r2_en = 1'b1; imm = imm_sext; end
      6'h06: begin br = BrLez; r1_en = 1'b1; imm = imm_sext; end
      6'h07: begin br = BrGtz; r1_en = 1'b1; imm = imm_sext; end
      6'h09: begin dec_alu = AluAdd; ri = 1'b1; imm = imm_sext; end
      6'h0c: begin dec_alu = AluAnd; ri = 1'b1; imm = imm_zext; end
      6'h0d: begin dec_alu = AluOr;  ri = 1'b1; imm = imm_zext; end
      6'h0e: begin dec_alu = AluXor; ri = 1'b1; imm = imm_zext; end
      6'h0f: begin dec_alu = AluOr;  ri = 1'b1; r1_addr = '0; imm = imm_lui; end
      6'h23: begin dec_alu = AluLoad; ri = 1'b1; imm = imm_sext; end
      default: ;
    endcase
    if (rr) begin
      r1_en = 1'b1;
      r2_en = 1'b1;
      wr_en = 1'b1;
    end
    if (ri) begin
      r1_en   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = rt;
    end
  end

  assign rf_r1_en   = r1_en;
  assign rf_r2_en   = r2_en;
  assign rf_r1_addr = r1_addr;
  assign rf_r2_addr = r2_addr;

  // Lowest-numbered (youngest) matching port wins, so scan from the top down.
  function automatic logic [DATA_W-1:0] resolve(
    input logic                         en,
    input logic [RADDR_W-1:0]           a,
    input logic [DATA_W-1:0]            rf_d,
    input logic [DATA_W-1:0]            imm_v,
    input logic [FWD_PORTS-1:0]         f_en,
    input logic [FWD_PORTS*RADDR_W-1:0] f_addr,
    input logic [FWD_PORTS*DATA_W-1:0]  f_data
  );
    logic [DATA_W-1:0] v;
    if (!en) return imm_v;
    if (a == '0) return '0;
    v = rf_d;
    for (int i = int'(FWD_PORTS) - 1; i >= 0; i--) begin
      if (f_en[i] && (f_addr[i*RADDR_W +: RADDR_W] == a)) v = f_data[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  logic [DATA_W-1:0] op1, op2;

  always_comb begin
    op1 = resolve(r1_en, r1_addr, rf_r1_data, imm, fwd_en, fwd_addr, fwd_data);
    op2 = resolve(r2_en, r2_addr, rf_r2_data, imm, fwd_en, fwd_addr, fwd_data);
  end

  logic hazard;

  always_comb begin
    hazard = 1'b0;
    if ((LOAD_STALL_EN != 0) && fwd_en[0] && fwd_is_load[0]) begin
      hazard = (r1_en && (r1_addr != '0) && (r1_addr == fwd_addr[RADDR_W-1:0])) ||
               (r2_en && (r2_addr != '0) && (r2_addr == fwd_addr[RADDR_W-1:0]));
    end
  end

  logic              taken;
  logic [ADDR_W-1:0] tgt;

  always_comb begin
    taken = 1'b0;
    tgt   = br_tgt;
    case (br)
      BrEq:    taken = (op1 == op2);
      BrNe:    taken = (op1 != op2);
      BrLez:   taken = op1[DATA_W-1] || (op1 == '0);
      BrGtz:   taken = !op1[DATA_W-1] && (op1 != '0);
      BrJmp:   begin taken = 1'b1; tgt = j_tgt; end
      BrReg:   begin taken = 1'b1; tgt = ADDR_W'(op1); end
      default: ;
    endcase
  end

  logic accept;

  always_comb begin
    state_d  = StRun;
    if_ready = 1'b0;
    if (state_q == StRun) begin
      if (hazard && if_valid) state_d = StStall;
      if_ready = rst && !hazard && (!ex_valid || ex_ready);
    end
    accept    = if_valid && if_ready;
    jump_en   = accept && taken;
    jump_addr = tgt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_alu   <= '0;
      ex_oprd1 <= '0;
      ex_oprd2 <= '0;
      ex_wreg  <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_alu   <= dec_alu;
      ex_oprd1 <= link ? '0 : op1;
      ex_oprd2 <= op2;
      ex_wreg  <= wr_en ? {1'b1, wr_addr} : '0;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  logic unused_load;
  assign unused_load = ^fwd_is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode/forward/branch vector table plus stall,
// backpressure and reset sequences, checked through an expected-result queue.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_addr;
  logic        rf_r1_en, rf_r2_en;
  logic [4:0]  rf_r1_addr, rf_r2_addr;
  logic [31:0] rf_r1_data, rf_r2_data;
  logic [1:0]  fwd_en, fwd_is_load;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_alu;
  logic [31:0] ex_oprd1, ex_oprd2;
  logic [5:0]  ex_wreg;

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_addr(if_addr),
    .rf_r1_en(rf_r1_en), .rf_r2_en(rf_r2_en),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
    .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu(ex_alu),
    .ex_oprd1(ex_oprd1), .ex_oprd2(ex_oprd2), .ex_wreg(ex_wreg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, addr, rf1, rf2;
    logic [1:0]  fen;
    logic [9:0]  faddr;
    logic [63:0] fdata;
    logic        jmp;
    logic [31:0] jaddr;
    logic [3:0]  alu;
    logic [31:0] op1, op2;
    logic [5:0]  wreg;
    logic        chk_ops;
  } vec_t;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] op1, op2;
    logic [5:0]  wreg;
    logic        chk_ops;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_exp;
  bit   model_valid = 1'b0;
  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    if_inst     = v.inst;
    if_addr     = v.addr;
    rf_r1_data  = v.rf1;
    rf_r2_data  = v.rf2;
    fwd_en      = v.fen;
    fwd_addr    = v.faddr;
    fwd_data    = v.fdata;
    fwd_is_load = 2'b00;
  endtask

  // acc: bench expects the instruction to be accepted on this edge.
  task automatic clock_edge(input bit acc, input bit rdy);
    @(posedge clk);
    #1;
    if (acc) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        last_exp = sb.pop_front();
      end
      model_valid = 1'b1;
    end else if (rdy) begin
      model_valid = 1'b0;
    end
    check("ex_valid", ex_valid, model_valid);
    if (model_valid) begin
      check("ex_alu", ex_alu, last_exp.alu);
      check("ex_wreg", ex_wreg, last_exp.wreg);
      if (last_exp.chk_ops) begin
        check("ex_oprd1", ex_oprd1, last_exp.op1);
        check("ex_oprd2", ex_oprd2, last_exp.op2);
      end
    end
  endtask

  // Load in ex on port 0, then it moves to mem (port 1) carrying 0x5A5A.
  task automatic load_use(input logic [31:0] inst, input logic [31:0] addr, input bit is_br,
                          input exp_t e);
    if_valid = 1'b1; ex_ready = 1'b1;
    if_inst = inst; if_addr = addr; rf_r1_data = 32'h777; rf_r2_data = 32'h777;
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_data = {32'h0, 32'hDEAD}; fwd_is_load = 2'b01;
    #1;
    check("lu_hazard_if_ready", if_ready, 1'b0);
    check("lu_hazard_jump_en", jump_en, 1'b0);
    clock_edge(1'b0, 1'b1);
    fwd_en = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_data = {32'h5A5A, 32'h0}; fwd_is_load = 2'b00;
    #1;
    check("lu_stall_if_ready", if_ready, 1'b0);
    check("lu_stall_jump_en", jump_en, 1'b0);
    clock_edge(1'b0, 1'b1);
    #1;
    check("lu_run_if_ready", if_ready, 1'b1);
    check("lu_run_jump_en", jump_en, is_br);
    if (is_br) check("lu_run_jump_addr", jump_addr, 32'h110);
    sb.push_back(e);
    clock_edge(1'b1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h34011234, 32'h10,  32'h55,  32'h0,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd4,  32'h0,   32'h1234, 6'h21, 1'b1};
    vecs[1]  = '{32'h00221821, 32'h14,  32'h111, 32'h222, 2'b11, {5'd1, 5'd1},
                 {32'hBB, 32'hAA}, 1'b0, 32'h0, 4'd1, 32'hAA, 32'h222, 6'h23, 1'b1};
    vecs[2]  = '{32'h00021821, 32'h18,  32'h999, 32'h222, 2'b01, {5'd0, 5'd0},
                 {32'h0, 32'hCC},  1'b0, 32'h0, 4'd1, 32'h0,  32'h222, 6'h23, 1'b1};
    vecs[3]  = '{32'h00221821, 32'h1C,  32'h111, 32'h222, 2'b11, {5'd2, 5'd7},
                 {32'hBB, 32'h77}, 1'b0, 32'h0, 4'd1, 32'h111, 32'hBB, 6'h23, 1'b1};
    vecs[4]  = '{32'h10220003, 32'h100, 32'h5,   32'h5,   2'b00, 10'h0, 64'h0,
                 1'b1, 32'h110,  4'd0,  32'h5,   32'h5,   6'h00, 1'b1};
    vecs[5]  = '{32'h10220003, 32'h100, 32'h5,   32'h6,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd0,  32'h5,   32'h6,   6'h00, 1'b1};
    vecs[6]  = '{32'h14220003, 32'h100, 32'h5,   32'h6,   2'b00, 10'h0, 64'h0,
                 1'b1, 32'h110,  4'd0,  32'h5,   32'h6,   6'h00, 1'b1};
    vecs[7]  = '{32'h1C200003, 32'h100, 32'h80000000, 32'h0, 2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd0,  32'h80000000, 32'h3, 6'h00, 1'b1};
    vecs[8]  = '{32'h1C200003, 32'h100, 32'h1,   32'h0,   2'b00, 10'h0, 64'h0,
                 1'b1, 32'h110,  4'd0,  32'h1,   32'h3,   6'h00, 1'b1};
    vecs[9]  = '{32'h18200003, 32'h100, 32'h0,   32'h0,   2'b00, 10'h0, 64'h0,
                 1'b1, 32'h110,  4'd0,  32'h0,   32'h3,   6'h00, 1'b1};
    vecs[10] = '{32'h0C000040, 32'h2000, 32'h0,  32'h0,   2'b00, 10'h0, 64'h0,
                 1'b1, 32'h100,  4'd4,  32'h0,   32'h2008, 6'h3F, 1'b1};
    vecs[11] = '{32'h00200008, 32'h300, 32'h4000, 32'h0,  2'b00, 10'h0, 64'h0,
                 1'b1, 32'h4000, 4'd0,  32'h4000, 32'h0,  6'h00, 1'b1};
    vecs[12] = '{32'h00201009, 32'h300, 32'h4000, 32'h0,  2'b00, 10'h0, 64'h0,
                 1'b1, 32'h4000, 4'd4,  32'h0,   32'h308, 6'h22, 1'b1};
    vecs[13] = '{32'h00031100, 32'h304, 32'hDEAD, 32'hF0, 2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd8,  32'h4,   32'hF0,  6'h22, 1'b1};
    vecs[14] = '{32'h3C05ABCD, 32'h308, 32'hDEAD, 32'h0,  2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd4,  32'h0,   32'hABCD0000, 6'h25, 1'b1};
    vecs[15] = '{32'h2426FFFF, 32'h30C, 32'h10,  32'h0,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd1,  32'h10,  32'hFFFFFFFF, 6'h26, 1'b1};
    vecs[16] = '{32'h3026FFFF, 32'h310, 32'h10,  32'h0,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd3,  32'h10,  32'h0000FFFF, 6'h26, 1'b1};
    vecs[17] = '{32'h0022382B, 32'h314, 32'h3,   32'h4,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd7,  32'h3,   32'h4,   6'h27, 1'b1};
    vecs[18] = '{32'hFC000000, 32'h318, 32'h1,   32'h2,   2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd0,  32'h0,   32'h0,   6'h00, 1'b0};
    vecs[19] = '{32'h8C280004, 32'h31C, 32'h1000, 32'h0,  2'b00, 10'h0, 64'h0,
                 1'b0, 32'h0,    4'd11, 32'h1000, 32'h4,  6'h28, 1'b1};

    // Reset: J presented while held in reset must not be accepted or redirect.
    rst = 1'b0; if_valid = 1'b1; ex_ready = 1'b1;
    if_inst = 32'h08000040; if_addr = 32'h0;
    rf_r1_data = '0; rf_r2_data = '0;
    fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_is_load = '0;
    #12;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_alu", ex_alu, 4'd0);
    check("rst_ex_oprd1", ex_oprd1, 32'h0);
    check("rst_ex_oprd2", ex_oprd2, 32'h0);
    check("rst_ex_wreg", ex_wreg, 6'h0);
    check("rst_if_ready", if_ready, 1'b0);
    check("rst_jump_en", jump_en, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_if_ready", i), if_ready, 1'b1);
      check($sformatf("v%0d_jump_en", i), jump_en, vecs[i].jmp);
      if (vecs[i].jmp) check($sformatf("v%0d_jump_addr", i), jump_addr, vecs[i].jaddr);
      sb.push_back('{vecs[i].alu, vecs[i].op1, vecs[i].op2, vecs[i].wreg, vecs[i].chk_ops});
      clock_edge(1'b1, 1'b1);
    end

    load_use(32'h00842821, 32'h400, 1'b0, '{4'd1, 32'h5A5A, 32'h5A5A, 6'h25, 1'b1});
    load_use(32'h10840003, 32'h100, 1'b1, '{4'd0, 32'h5A5A, 32'h5A5A, 6'h00, 1'b1});

    // Backpressure: fields hold for 3 cycles, then async reset mid-cycle.
    apply(vecs[0]);
    sb.push_back('{vecs[0].alu, vecs[0].op1, vecs[0].op2, vecs[0].wreg, 1'b1});
    clock_edge(1'b1, 1'b1);
    ex_ready = 1'b0;
    apply(vecs[1]);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_if_ready", k), if_ready, 1'b0);
      check($sformatf("bp%0d_jump_en", k), jump_en, 1'b0);
      clock_edge(1'b0, 1'b0);
    end
    #2;
    rst = 1'b0;
    #1;
    check("bp_rst_ex_valid", ex_valid, 1'b0);
    check("bp_rst_ex_alu", ex_alu, 4'd0);
    check("bp_rst_if_ready", if_ready, 1'b0);
    model_valid = 1'b0;
    sb.delete();
    #1;
    rst = 1'b1; ex_ready = 1'b1;
    #1;
    check("bp_post_rst_if_ready", if_ready, 1'b1);
    if_valid = 1'b0;
    clock_edge(1'b0, 1'b1);

    // Reset while in the stall state must return the FSM to run.
    if_valid = 1'b1;
    if_inst = 32'h00842821; if_addr = 32'h500; rf_r1_data = 32'h777; rf_r2_data = 32'h777;
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_data = {32'h0, 32'hDEAD}; fwd_is_load = 2'b01;
    #1;
    check("ms_hazard_if_ready", if_ready, 1'b0);
    clock_edge(1'b0, 1'b1);
    fwd_en = 2'b00; fwd_is_load = 2'b00;
    #1;
    check("ms_stall_if_ready", if_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("ms_rst_ex_valid", ex_valid, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("ms_run_if_ready", if_ready, 1'b1);
    sb.push_back('{4'd1, 32'h777, 32'h777, 6'h25, 1'b1});
    clock_edge(1'b1, 1'b1);
    if_valid = 1'b0;
    clock_edge(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
